// File: rtl/pipelined_add_sub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: mode encoding and split helpers.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package pipelined_add_sub_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    // Operands are cut into equal chunks, so the width has to divide evenly.
    function automatic bit split_ok(input int width, input int stages);
        return (stages > 0) && (width >= stages) && ((width % stages) == 0);
    endfunction

    // Subtraction is A + ~B + 1, so the stage 0 carry replaces carry_in.
    function automatic logic chunk0_cin(input mode_e mode, input logic carry_in);
        return (mode == MODE_SUB) ? 1'b1 : carry_in;
    endfunction

endpackage

// File: rtl/pipelined_add_sub_if.sv
// Operand/result handshake bundle between producers, the adder pipeline and consumers.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carry the valid-ready flow control in each direction.
interface pipelined_add_sub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] input_a;
    logic [WIDTH-1:0] input_b;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output in_valid, input_a, input_b, carry_in, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, input_a, input_b, carry_in, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/add_chunk_stage.sv
// One CHUNK-bit slice of the ripple pipeline: chunk add plus registered sum, carry and valid.
// Latency: 1 cycle.
// Backpressure: all registers hold while en is low.
module add_chunk_stage #(
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_vld,
    input  logic [CHUNK-1:0] a_dat,
    input  logic [CHUNK-1:0] b_dat,
    input  logic             cin,
    output logic             vld,
    output logic [CHUNK-1:0] sum_dat,
    output logic             cout,
    output logic             ovf
);
    logic [CHUNK:0] full;
    logic           c_msb;

    // Carry into the chunk MSB recovered from the sum bit, so CHUNK=1 needs no special case.
    always_comb begin
        full  = {1'b0, a_dat} + {1'b0, b_dat} + {{CHUNK{1'b0}}, cin};
        c_msb = a_dat[CHUNK-1] ^ b_dat[CHUNK-1] ^ full[CHUNK-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld     <= 1'b0;
            sum_dat <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (en) begin
            vld     <= in_vld;
            sum_dat <= full[CHUNK-1:0];
            cout    <= full[CHUNK];
            ovf     <= c_msb ^ full[CHUNK];
        end
    end
endmodule

// File: rtl/pipelined_add_sub.sv
// WIDTH-bit add/subtract resolved one CHUNK per stage with registered carries between stages.
// Latency: STAGES cycles, plus one per stall cycle; one op per cycle at steady state.
// Backpressure: a stalled output holds every stage and drops in_ready in the same cycle.
module pipelined_add_sub
    import pipelined_add_sub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic                clk,
    input logic                rst,
    pipelined_add_sub_if.slave bus
);
    localparam int CHUNK = WIDTH / STAGES;

    if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
        $error("pipelined_add_sub: WIDTH (%0d) must split evenly into STAGES (%0d)", WIDTH, STAGES);
    end

    mode_e            mode;
    logic [WIDTH-1:0] b_eff;
    logic             cin0;
    logic             stall;
    logic             adv;

    assign mode  = mode_e'(bus.sub);
    assign b_eff = (mode == MODE_SUB) ? ~bus.input_b : bus.input_b;
    assign cin0  = chunk0_cin(mode, bus.carry_in);

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * CHUNK;

        // a_op/b_op: operand chunks k..STAGES-1 seen by this stage; res: result chunks 0..k.
        logic [WIDTH-1:LO]     a_op;
        logic [WIDTH-1:LO]     b_op;
        logic [LO+CHUNK-1:0]   res;
        logic [CHUNK-1:0]      chunk;
        logic                  s_cin;
        logic                  s_vld_in;
        logic                  vld;
        logic                  cout;
        logic                  ovf;

        if (k == 0) begin : g_head
            assign a_op     = bus.input_a;
            assign b_op     = b_eff;
            assign s_cin    = cin0;
            assign s_vld_in = bus.in_valid;
            assign res      = chunk;
        end else begin : g_body
            logic [WIDTH-1:LO] a_skw;
            logic [WIDTH-1:LO] b_skw;
            logic [LO-1:0]     dsk;

            // Skew/deskew move in lockstep with the stage registers so an op stays aligned.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_skw <= '0;
                    b_skw <= '0;
                    dsk   <= '0;
                end else if (adv) begin
                    a_skw <= g_stg[k-1].a_op[WIDTH-1:LO];
                    b_skw <= g_stg[k-1].b_op[WIDTH-1:LO];
                    dsk   <= g_stg[k-1].res;
                end
            end

            assign a_op     = a_skw;
            assign b_op     = b_skw;
            assign s_cin    = g_stg[k-1].cout;
            assign s_vld_in = g_stg[k-1].vld;
            assign res      = {chunk, dsk};
        end

        add_chunk_stage #(
            .CHUNK (CHUNK)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (adv),
            .in_vld  (s_vld_in),
            .a_dat   (a_op[LO +: CHUNK]),
            .b_dat   (b_op[LO +: CHUNK]),
            .cin     (s_cin),
            .vld     (vld),
            .sum_dat (chunk),
            .cout    (cout),
            .ovf     (ovf)
        );
    end

    // Only the last stage can be blocked, so its valid alone decides the stall.
    assign stall         = g_stg[STAGES-1].vld & ~bus.out_ready;
    assign adv           = ~stall;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = g_stg[STAGES-1].vld;
    assign bus.sum       = g_stg[STAGES-1].res;
    assign bus.carry_out = g_stg[STAGES-1].cout;
    assign bus.overflow  = g_stg[STAGES-1].ovf;
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub at WIDTH=16, STAGES=4 with hand-computed expectations.
// Covers reset, add/sub corner values, back-to-back flow, output stalls and mid-flight reset.
module tb_pipelined_add_sub;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    vec_t tbl [6];
    vec_t v;

    always #5 clk = ~clk;

    pipelined_add_sub_if #(.WIDTH(16)) bus ();

    pipelined_add_sub #(
        .WIDTH  (16),
        .STAGES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t op);
        bus.in_valid = 1'b1;
        bus.input_a  = op.a;
        bus.input_b  = op.b;
        bus.carry_in = op.cin;
        bus.sub      = op.sub;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input vec_t op);
        chk({tag, "_sum"}, {16'd0, bus.sum}, {16'd0, op.s});
        chk({tag, "_co"},  {31'd0, bus.carry_out}, {31'd0, op.co});
        chk({tag, "_ov"},  {31'd0, bus.overflow}, {31'd0, op.ov});
    endtask

    // One isolated op: valid must rise exactly on the 4th cycle, then drain.
    task automatic single(input string tag, input vec_t op);
        drive(op);
        for (int t = 1; t <= 4; t++) begin
            tick();
            if (t == 1) idle();
            chk($sformatf("%s_vld_c%0d", tag, t), {31'd0, bus.out_valid}, {31'd0, (t == 4)});
        end
        check_result(tag, op);
        tick();
        chk({tag, "_drain"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int tx;
        int rx;
        bit acc;
        bit dlv;

        tbl[0] = '{a:16'd100,    b:16'd200,    cin:1'b0, sub:1'b0, s:16'd300,    co:1'b0, ov:1'b0};
        tbl[1] = '{a:16'hFFFF,   b:16'hFFFF,   cin:1'b1, sub:1'b0, s:16'hFFFF,   co:1'b1, ov:1'b0};
        tbl[2] = '{a:16'h8000,   b:16'h8000,   cin:1'b0, sub:1'b0, s:16'h0000,   co:1'b1, ov:1'b1};
        tbl[3] = '{a:16'd500,    b:16'd500,    cin:1'b1, sub:1'b1, s:16'h0000,   co:1'b1, ov:1'b0};
        tbl[4] = '{a:16'h8000,   b:16'h0001,   cin:1'b0, sub:1'b1, s:16'h7FFF,   co:1'b1, ov:1'b1};
        tbl[5] = '{a:16'h1234,   b:16'h4321,   cin:1'b1, sub:1'b0, s:16'h5556,   co:1'b0, ov:1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.input_a   = '0;
        bus.input_b   = '0;
        bus.carry_in  = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_sum",       {16'd0, bus.sum}, 32'd0);
        chk("rst_co",        {31'd0, bus.carry_out}, 32'd0);
        chk("rst_ov",        {31'd0, bus.overflow}, 32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        rst = 1'b0;
        tick();
        chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);

        // Isolated ops
        v = '{a:16'd3237,  b:16'd1172,  cin:1'b1, sub:1'b0, s:16'd4410,  co:1'b0, ov:1'b0};
        single("add_cin", v);
        v = '{a:16'd65535, b:16'd1,     cin:1'b0, sub:1'b0, s:16'd0,     co:1'b1, ov:1'b0};
        single("wrap", v);
        v = '{a:16'h7FFF,  b:16'd1,     cin:1'b0, sub:1'b0, s:16'h8000,  co:1'b0, ov:1'b1};
        single("sovf", v);
        v = '{a:16'd2434,  b:16'd12,    cin:1'b0, sub:1'b1, s:16'd2422,  co:1'b1, ov:1'b0};
        single("sub_pos", v);
        v = '{a:16'd12,    b:16'd2434,  cin:1'b1, sub:1'b1, s:16'd63114, co:1'b0, ov:1'b0};
        single("sub_neg", v);

        // Back-to-back, out_ready held high
        drive(tbl[0]);
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t < 6) drive(tbl[t]); else idle();
            chk($sformatf("b2b_vld_c%0d", t), {31'd0, bus.out_valid}, {31'd0, (t >= 4 && t <= 9)});
            if (t >= 4 && t <= 9) check_result($sformatf("b2b%0d", t - 4), tbl[t - 4]);
        end

        // Back-pressure: consumer refuses for 3 cycles once the first result shows
        tx  = 0;
        rx  = 0;
        acc = 1'b0;
        dlv = 1'b0;
        for (int t = 0; t < 24; t++) begin
            if (t > 0) tick();
            if (acc) tx++;
            if (dlv) rx++;
            if (tx < 6) drive(tbl[tx]); else idle();
            bus.out_ready = !(t >= 4 && t <= 6);
            #1;
            if (t >= 4 && t <= 6) begin
                chk($sformatf("bp_stall_vld_c%0d", t), {31'd0, bus.out_valid}, 32'd1);
                chk($sformatf("bp_stall_rdy_c%0d", t), {31'd0, bus.in_ready}, 32'd0);
            end
            if (rx >= 6)
                chk($sformatf("bp_extra_c%0d", t), {31'd0, bus.out_valid}, 32'd0);
            else if (bus.out_valid)
                check_result($sformatf("bp%0d", rx), tbl[rx]);
            acc = bus.in_valid && bus.in_ready;
            dlv = bus.out_valid && bus.out_ready;
        end
        chk("bp_received", rx, 32'd6);
        chk("bp_sent", tx, 32'd6);
        idle();
        bus.out_ready = 1'b1;
        tick();

        // Reset with three ops in flight, oldest parked at the output
        bus.out_ready = 1'b0;
        drive(tbl[1]);
        tick();
        drive(tbl[4]);
        tick();
        drive(tbl[5]);
        tick();
        idle();
        tick();
        chk("mid_pre_vld", {31'd0, bus.out_valid}, 32'd1);
        chk("mid_pre_sum", {16'd0, bus.sum}, {16'd0, tbl[1].s});
        rst = 1'b1;
        #1;
        chk("mid_rst_vld",   {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_sum",   {16'd0, bus.sum}, 32'd0);
        chk("mid_rst_co",    {31'd0, bus.carry_out}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            tick();
            chk($sformatf("mid_quiet_c%0d", t), {31'd0, bus.out_valid}, 32'd0);
        end
        single("recover", tbl[2]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
